// File: rtl/blueintegral_mat_pkg.sv
// Shared constants and phase encoding for the binary matrix multiplier datapath.
// Used by the operand loader, the multiplier and any later stages.
package blueintegral_mat_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned COUNT_W   = 4;

    // Loader phase; the encoding is visible on the debug pins.
    typedef enum logic [1:0] {
        WAIT_A     = 2'b00,
        WAIT_B     = 2'b01,
        FULL       = 2'b10,
        PHASE_RSVD = 2'b11
    } phase_e;

endpackage

// File: rtl/blueintegral_sync.sv
// Multi-stage flop chain for bringing pin-level signals into the clk domain.
// All bits travel through the same number of stages, so bundled bits stay aligned.
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset, clears every stage
//   d_i      asynchronous input bundle
//   q_o      synchronised bundle, Stages edges behind d_i
module blueintegral_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [Stages];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(Stages); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(Stages); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/blueintegral_operand_loader.sv
// Operand loader for the 2x2 binary matrix multiplier. Collects two 4-bit nibbles
// (A then B), each marked by a rising edge on a slow asynchronous pin strobe, and
// presents the double-buffered {A,B} word to the multiplier.
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   data_in        nibble from the pins
//   load_strb      asynchronous strobe, one nibble per rising edge
//   operand_data   {A,B} word for the multiplier, changes only on a B capture
//   operand_valid  set once a full pair has been captured
//   phase          loader phase encoding for debug
//   load_count     completed pairs modulo 16
// SYNC_STAGES: synchroniser depth, legal range 2..4.
module blueintegral_operand_loader
    import blueintegral_mat_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIBBLE_W-1:0]  data_in,
    input  logic                 load_strb,
    output logic [OPERAND_W-1:0] operand_data,
    output logic                 operand_valid,
    output logic [1:0]           phase,
    output logic [COUNT_W-1:0]   load_count
);

    localparam int unsigned SyncW = NIBBLE_W + 2;

    logic [SyncW-1:0]    sync_out;
    logic                sync_filled;
    logic                strb_s;
    logic [NIBBLE_W-1:0] nib_s;

    // The constant 1 rides the chain next to the strobe: it marks the point where the
    // synchroniser output reflects the pin rather than its own reset zeros. Without it
    // a strobe held high through reset release would look low for a few cycles and arm.
    blueintegral_sync #(
        .Width  (SyncW),
        .Stages (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     ({1'b1, load_strb, data_in}),
        .q_o     (sync_out)
    );

    assign sync_filled = sync_out[SyncW-1];
    assign strb_s      = sync_out[NIBBLE_W];
    assign nib_s       = sync_out[NIBBLE_W-1:0];

    logic                 strb_prev_q, strb_prev_d;
    logic                 armed_q, armed_d;
    phase_e               phase_q, phase_d;
    logic [NIBBLE_W-1:0]  a_stage_q, a_stage_d;
    logic [OPERAND_W-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 cap;

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            phase_q     <= WAIT_A;
            a_stage_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            strb_prev_q <= strb_prev_d;
            armed_q     <= armed_d;
            phase_q     <= phase_d;
            a_stage_q   <= a_stage_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        strb_prev_d = strb_s;
        armed_d     = armed_q | (sync_filled & ~strb_s);
        phase_d     = phase_q;
        a_stage_d   = a_stage_q;
        data_d      = data_q;
        valid_d     = valid_q;
        count_d     = count_q;

        cap = strb_s & ~strb_prev_q & armed_q;

        case (phase_q)
            WAIT_A, FULL: begin
                if (cap) begin
                    a_stage_d = nib_s;
                    phase_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                // Only the B capture touches the multiplier-facing registers.
                if (cap) begin
                    data_d  = {a_stage_q, nib_s};
                    valid_d = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                    phase_d = FULL;
                end
            end
            default: begin
                phase_d = WAIT_A;
            end
        endcase
    end

    assign operand_data  = data_q;
    assign operand_valid = valid_q;
    assign phase         = phase_q;
    assign load_count    = count_q;

endmodule

// File: tb/tb_blueintegral_operand_loader.sv
// Bench for blueintegral_operand_loader: three instances (depth 2, 3, 4) share one
// stimulus stream and are compared against a behavioural pair-assembly model.
module tb_blueintegral_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       load_strb;

    logic [7:0] od [3];
    logic       ov [3];
    logic [1:0] ph [3];
    logic [3:0] lc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        blueintegral_operand_loader #(
            .SYNC_STAGES (g + 2)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .data_in       (data_in),
            .load_strb     (load_strb),
            .operand_data  (od[g]),
            .operand_valid (ov[g]),
            .phase         (ph[g]),
            .load_count    (lc[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tracks nibbles delivered and what pair has been assembled.
    logic       m_have_a;
    logic       m_full;
    logic [3:0] m_a;
    logic [7:0] m_data;
    logic       m_valid;
    int         m_pairs;
    logic       m_armed;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] m_phase();
        if (m_have_a) return 2'b01;
        if (m_full)   return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_have_a = 1'b0;
        m_full   = 1'b0;
        m_a      = 4'h0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_pairs  = 0;
        m_armed  = 1'b0;
    endtask

    task automatic model_deliver(input logic [3:0] n);
        if (!m_armed) return;
        if (m_have_a) begin
            m_data   = {m_a, n};
            m_valid  = 1'b1;
            m_pairs  = m_pairs + 1;
            m_have_a = 1'b0;
            m_full   = 1'b1;
        end else begin
            m_a      = n;
            m_have_a = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s.s%0d.data", tag, d + 2), 32'(od[d]), 32'(m_data));
            check_eq($sformatf("%s.s%0d.valid", tag, d + 2), 32'(ov[d]), 32'(m_valid));
            check_eq($sformatf("%s.s%0d.phase", tag, d + 2), 32'(ph[d]), 32'(m_phase()));
            check_eq($sformatf("%s.s%0d.count", tag, d + 2), 32'(lc[d]), 32'(m_pairs % 16));
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        model_clear();
        if (!load_strb) begin
            repeat (6) @(negedge clk);
            m_armed = 1'b1;
        end
    endtask

    task automatic drive_nibble(input logic [3:0] n, input int hi, input int lo);
        @(negedge clk);
        data_in = n;
        @(negedge clk);
        load_strb = 1'b1;
        repeat (hi) @(negedge clk);
        load_strb = 1'b0;
        repeat (lo) @(negedge clk);
        model_deliver(n);
        m_armed = 1'b1;
    endtask

    // Sends one nibble and measures, per instance, how many edges after the sampling
    // edge operand_data changes. Requires the nibble to complete a pair with new data.
    task automatic drive_timed(input string tag, input logic [3:0] n);
        int         lat [3];
        logic [7:0] prev [3];
        @(negedge clk);
        data_in = n;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            lat[d]  = 0;
            prev[d] = od[d];
        end
        load_strb = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && od[d] !== prev[d]) lat[d] = e;
            end
        end
        @(negedge clk);
        load_strb = 1'b0;
        repeat (4) @(negedge clk);
        model_deliver(n);
        m_armed = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s.s%0d.latency", tag, d + 2), 32'(lat[d]), 32'(d + 2));
        end
    endtask

    initial begin
        reset     = 1'b1;
        load_strb = 1'b0;
        data_in   = 4'h0;
        model_clear();
        repeat (2) @(negedge clk);
        check_model("reset");

        // Basic load and double buffering.
        do_reset(2);
        drive_nibble(4'b1011, 3, 3);
        settle();
        check_model("basic_a");
        drive_timed("basic_b", 4'b0110);
        check_eq("basic.data_b6", 32'(od[0]), 32'h0000_00B6);
        check_model("basic");
        drive_nibble(4'hF, 3, 3);
        settle();
        check_model("dbuf_a");
        drive_timed("dbuf_b", 4'hF);
        check_eq("dbuf.data_ff", 32'(od[0]), 32'h0000_00FF);
        check_model("dbuf");

        // Long strobe yields one capture.
        do_reset(2);
        drive_nibble(4'h9, 20, 4);
        settle();
        check_model("held");

        // Strobe high across reset release: nothing until low then high again.
        @(negedge clk);
        data_in = 4'h5;
        @(negedge clk);
        load_strb = 1'b1;
        repeat (4) @(negedge clk);
        do_reset(2);
        repeat (20) @(negedge clk);
        check_model("held_rst_high");
        load_strb = 1'b0;
        repeat (6) @(negedge clk);
        m_armed = 1'b1;
        check_model("held_rst_low");
        drive_nibble(4'hC, 3, 3);
        settle();
        check_model("held_rst_rearm");

        // Reset mid-load discards the staged A.
        do_reset(2);
        drive_nibble(4'h3, 3, 3);
        settle();
        do_reset(1);
        drive_nibble(4'h5, 3, 3);
        drive_nibble(4'hA, 3, 3);
        settle();
        check_eq("midrst.data_5a", 32'(od[0]), 32'h0000_005A);
        check_model("midrst");

        // Counter wrap over 17 pairs.
        do_reset(2);
        for (int p = 1; p <= 17; p++) begin
            drive_nibble(4'($urandom_range(0, 15)), 2, 2);
            drive_nibble(4'($urandom_range(0, 15)), 2, 2);
            settle();
            check_model($sformatf("wrap%0d", p));
        end
        check_eq("wrap.count_final", 32'(lc[0]), 32'h1);

        // Randomised timing, data and occasional resets.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
            drive_nibble(4'($urandom_range(0, 15)), $urandom_range(2, 6),
                         $urandom_range(2, 5));
            settle();
            check_model($sformatf("rand%0d", i));
        end

        // Back-to-back nibbles at minimum pin timing.
        for (int i = 0; i < 12; i++) begin
            drive_nibble(4'($urandom_range(0, 15)), 2, 2);
        end
        settle();
        check_model("burst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
